sound_event_sequencer: RTL and testbench

//  Parametrised successor to the single-octave tone decoder. Latches one-shot sound requests

---
 rtl/sound_event_sequencer_if.sv | 29 ++
 rtl/sound_event_sequencer.sv | 155 +++++++++++++++
 tb/tb_sound_event_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sound_event_sequencer_if.sv
// Sound sequencer request/table/tone bundle.
// Game logic drives the master side; the sequencer is the slave.
interface sound_event_sequencer_if #(
  parameter int CHANNELS  = 6,
  parameter int PS_WIDTH  = 10,
  parameter int DUR_WIDTH = 8
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]           request;
  logic [CHANNELS*PS_WIDTH-1:0]  tone_table;
  logic [CHANNELS*DUR_WIDTH-1:0] dur_table;
  logic [PS_WIDTH-1:0]           preScaleValue;
  logic                          enableSound;
  logic [CW-1:0]                 active_ch;
  logic                          busy;

  modport master (
    output request, tone_table, dur_table,
    input  preScaleValue, enableSound,
    input  active_ch, busy
  );

  modport slave (
    input  request, tone_table, dur_table,
    output preScaleValue, enableSound,
    output active_ch, busy
  );
endinterface

// File: rtl/sound_event_sequencer.sv
// Priority sequencer for one-shot game sound events.
// Plays a latched tone for N ticks, then a silent gap.
module sound_event_sequencer #(
  parameter int CHANNELS  = 6,
  parameter int PS_WIDTH  = 10,
  parameter int DUR_WIDTH = 8,
  parameter int TICK_DIV  = 25000,
  parameter int GAP_TICKS = 2,
  parameter int PREEMPT   = 1
) (
  input  logic clk,
  input  logic resetN,
  sound_event_sequencer_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t state, stateN;

  logic [CHANNELS-1:0]  reqD, pending, rise, pendClr;
  logic [TW-1:0]        tickCnt;
  logic                 tick;
  logic [DUR_WIDTH-1:0] durCnt, durCntN;
  logic [GW-1:0]        gapCnt, gapCntN;
  logic [PS_WIDTH-1:0]  psR, psN;
  logic [CW-1:0]        chR, chN;
  logic                 enR, enN;
  logic                 busyR, busyN;
  logic [CW-1:0]        sel;
  logic                 anyPend;
  logic                 hiPend;
  logic [PS_WIDTH-1:0]  selTone;
  logic [DUR_WIDTH-1:0] selDur;

  assign rise = bus.request & ~reqD;
  assign tick = (tickCnt == TW'(TICK_DIV - 1));

  assign bus.preScaleValue = psR;
  assign bus.enableSound   = enR;
  assign bus.active_ch     = chR;
  assign bus.busy          = busyR;

  // Free-running tick divider, independent of the FSM.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) tickCnt <= '0;
    else if (tick) tickCnt <= '0;
    else tickCnt <= tickCnt + TW'(1);
  end

  // Edge detect and pending set/clear; a new rise beats a clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      reqD    <= '0;
      pending <= '0;
    end else begin
      reqD    <= bus.request;
      pending <= (pending & ~pendClr) | rise;
    end
  end

  // Fixed-priority pick of the lowest pending index and its table entries.
  always_comb begin
    sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (pending[i]) sel = CW'(i);
    anyPend = |pending;
    hiPend  = (PREEMPT != 0) && anyPend && (sel < chR);
    selTone = bus.tone_table[int'(sel)*PS_WIDTH +: PS_WIDTH];
    selDur  = bus.dur_table[int'(sel)*DUR_WIDTH +: DUR_WIDTH];
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      durCnt <= '0;
      gapCnt <= '0;
      psR    <= '0;
      chR    <= '0;
      enR    <= 1'b0;
      busyR  <= 1'b0;
    end else begin
      state  <= stateN;
      durCnt <= durCntN;
      gapCnt <= gapCntN;
      psR    <= psN;
      chR    <= chN;
      enR    <= enN;
      busyR  <= busyN;
    end
  end

  // Next state: load, count down the note, then the gap.
  always_comb begin
    stateN  = state;
    durCntN = durCnt;
    gapCntN = gapCnt;
    psN     = psR;
    chN     = chR;
    enN     = enR;
    busyN   = busyR;
    pendClr = '0;
    unique case (state)
      IDLE: begin
        if (anyPend) begin
          pendClr[sel] = 1'b1;
          if (selDur != '0) begin
            stateN  = PLAY;
            chN     = sel;
            psN     = selTone;
            durCntN = selDur;
            enN     = 1'b1;
            busyN   = 1'b1;
          end
        end
      end
      PLAY: begin
        if (hiPend) pendClr[sel] = 1'b1;
        if (hiPend && selDur != '0) begin
          chN     = sel;
          psN     = selTone;
          durCntN = selDur;
        end else if (tick) begin
          if (durCnt == DUR_WIDTH'(1)) begin
            enN = 1'b0;
            psN = '0;
            if (GAP_TICKS == 0) begin
              stateN = IDLE;
              busyN  = 1'b0;
            end else begin
              stateN  = GAP;
              gapCntN = GW'(GAP_TICKS);
            end
          end else begin
            durCntN = durCnt - DUR_WIDTH'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gapCnt == GW'(1)) begin
            stateN = IDLE;
            busyN  = 1'b0;
          end else begin
            gapCntN = gapCnt - GW'(1);
          end
        end
      end
      default: stateN = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer.
// Tick = 4 clocks, gap = 1 tick (4 clocks).
module tb_sound_event_sequencer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_event_sequencer_if #(.CHANNELS(6), .PS_WIDTH(10), .DUR_WIDTH(8)) bus ();
  sound_event_sequencer_if #(.CHANNELS(6), .PS_WIDTH(10), .DUR_WIDTH(8)) busB ();

  sound_event_sequencer #(
    .CHANNELS(6), .PS_WIDTH(10), .DUR_WIDTH(8),
    .TICK_DIV(4), .GAP_TICKS(1), .PREEMPT(1)
  ) dut (.clk(clk), .resetN(resetN), .bus(bus));

  sound_event_sequencer #(
    .CHANNELS(6), .PS_WIDTH(10), .DUR_WIDTH(8),
    .TICK_DIV(4), .GAP_TICKS(1), .PREEMPT(0)
  ) dutB (.clk(clk), .resetN(resetN), .bus(busB));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkRange(input string tag, input int obs,
                          input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Wait until enableSound (or busy) of dut / dutB equals val.
  task automatic waitSig(input string tag, input bit useB,
                         input bit selBusy, input logic val);
    int n;
    logic s;
    n = 0;
    forever begin
      if (useB) s = selBusy ? busB.busy : busB.enableSound;
      else s = selBusy ? bus.busy : bus.enableSound;
      if (s == val || n >= 100) break;
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, s}, {31'd0, val});
  endtask

  // Count cycles while enableSound (or busy) stays high.
  task automatic runLen(input bit selBusy, output int len);
    len = 0;
    while ((selBusy ? bus.busy : bus.enableSound) && len < 60) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic monitor(input int n, output int rises, output int onCyc,
                         output int busyCyc, output logic [2:0] c1,
                         output logic [2:0] c2);
    logic prev;
    prev = bus.enableSound;
    rises = 0;
    onCyc = 0;
    busyCyc = 0;
    c1 = 3'h7;
    c2 = 3'h7;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.enableSound && !prev) begin
        if (rises == 0) c1 = bus.active_ch;
        else if (rises == 1) c2 = bus.active_ch;
        rises++;
      end
      if (bus.enableSound) onCyc++;
      if (bus.busy) busyCyc++;
      prev = bus.enableSound;
    end
  endtask

  task automatic pulse(input bit useB, input int ch);
    if (useB) busB.request[ch] = 1'b1;
    else bus.request[ch] = 1'b1;
    @(negedge clk);
    if (useB) busB.request[ch] = 1'b0;
    else bus.request[ch] = 1'b0;
  endtask

  initial begin
    int len, rs, on, bz;
    logic [2:0] c1, c2;
    bus.request = '0;
    busB.request = '0;
    bus.tone_table = {10'h0E5, 10'h0D4, 10'h0C3, 10'h0B2, 10'h0A1, 10'h175};
    bus.dur_table  = {8'd8, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
    busB.tone_table = bus.tone_table;
    busB.dur_table  = bus.dur_table;

    repeat (2) @(negedge clk);
    chk("rst_en", {31'd0, bus.enableSound}, 0);
    chk("rst_ps", {22'd0, bus.preScaleValue}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_ch", {29'd0, bus.active_ch}, 0);
    resetN = 1'b1;
    repeat (3) @(negedge clk);

    // 1) single note, latency, length, gap
    bus.request[0] = 1'b1;
    @(negedge clk);
    bus.request[0] = 1'b0;
    chk("t1_lat1", {31'd0, bus.enableSound}, 0);
    @(negedge clk);
    chk("t1_en", {31'd0, bus.enableSound}, 1);
    chk("t1_ps", {22'd0, bus.preScaleValue}, 10'h175);
    chk("t1_ch", {29'd0, bus.active_ch}, 0);
    chk("t1_busy", {31'd0, bus.busy}, 1);
    runLen(1'b0, len);
    chkRange("t1_len", len, 9, 12);
    chk("t1_gapps", {22'd0, bus.preScaleValue}, 0);
    runLen(1'b1, len);
    chk("t1_gap", len, 4);
    chk("t1_idle", {31'd0, bus.busy}, 0);

    // 2) held level plays exactly once
    bus.request[3] = 1'b1;
    monitor(40, rs, on, bz, c1, c2);
    bus.request[3] = 1'b0;
    chk("t2_rises", rs, 1);
    chk("t2_ch", {29'd0, c1}, 3);
    chkRange("t2_len", on, 5, 8);
    monitor(20, rs, on, bz, c1, c2);
    chk("t2_noretrig", rs, 0);
    chk("t2_idle", {31'd0, bus.busy}, 0);

    // 3) simultaneous rises: priority order
    bus.request[2] = 1'b1;
    bus.request[4] = 1'b1;
    @(negedge clk);
    bus.request = '0;
    monitor(60, rs, on, bz, c1, c2);
    chk("t3_rises", rs, 2);
    chk("t3_first", {29'd0, c1}, 2);
    chk("t3_second", {29'd0, c2}, 4);

    // 4a) preemption of ch5 by ch1
    pulse(1'b0, 5);
    waitSig("t4_start", 1'b0, 1'b0, 1'b1);
    chk("t4_ch5", {29'd0, bus.active_ch}, 5);
    repeat (7) @(negedge clk);
    pulse(1'b0, 1);
    chk("t4_hold", {29'd0, bus.active_ch}, 5);
    @(negedge clk);
    chk("t4_pre_ch", {29'd0, bus.active_ch}, 1);
    chk("t4_pre_ps", {22'd0, bus.preScaleValue}, 10'h0A1);
    chk("t4_pre_en", {31'd0, bus.enableSound}, 1);
    runLen(1'b0, len);
    chkRange("t4_len1", len, 5, 8);
    runLen(1'b1, len);
    chk("t4_gap", len, 4);
    monitor(40, rs, on, bz, c1, c2);
    chk("t4_noresume", bz, 0);
    chk("t4_hold_ch", {29'd0, bus.active_ch}, 1);

    // 4b) no preemption: ch1 waits for ch5 and gap
    pulse(1'b1, 5);
    waitSig("t4b_start", 1'b1, 1'b0, 1'b1);
    repeat (7) @(negedge clk);
    pulse(1'b1, 1);
    repeat (3) @(negedge clk);
    chk("t4b_ch5", {29'd0, busB.active_ch}, 5);
    chk("t4b_ps5", {22'd0, busB.preScaleValue}, 10'h0E5);
    waitSig("t4b_end5", 1'b1, 1'b0, 1'b0);
    waitSig("t4b_gapend", 1'b1, 1'b1, 1'b0);
    waitSig("t4b_start1", 1'b1, 1'b0, 1'b1);
    chk("t4b_ch1", {29'd0, busB.active_ch}, 1);
    chk("t4b_ps1", {22'd0, busB.preScaleValue}, 10'h0A1);
    waitSig("t4b_done", 1'b1, 1'b1, 1'b0);

    // 5) muted channel
    bus.dur_table[7:0] = 8'd0;
    pulse(1'b0, 0);
    monitor(10, rs, on, bz, c1, c2);
    chk("t5_en", on, 0);
    chk("t5_busy", bz, 0);
    chk("t5_pend", {31'd0, dut.pending[0]}, 0);
    pulse(1'b0, 3);
    monitor(30, rs, on, bz, c1, c2);
    chk("t5_next", {29'd0, c1}, 3);

    // 6) reset mid-note with ch2 pending and ch4 held
    bus.dur_table[15:8] = 8'd8;
    pulse(1'b0, 1);
    waitSig("t6_start", 1'b0, 1'b0, 1'b1);
    bus.request[2] = 1'b1;
    bus.request[4] = 1'b1;
    @(negedge clk);
    bus.request[2] = 1'b0;
    @(negedge clk);
    chk("t6_pend", {26'd0, dut.pending}, 32'h14);
    resetN = 1'b0;
    #1;
    chk("t6_en", {31'd0, bus.enableSound}, 0);
    chk("t6_ps", {22'd0, bus.preScaleValue}, 0);
    chk("t6_busy", {31'd0, bus.busy}, 0);
    chk("t6_ch", {29'd0, bus.active_ch}, 0);
    chk("t6_pclr", {26'd0, dut.pending}, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    monitor(50, rs, on, bz, c1, c2);
    chk("t6_once", rs, 1);
    chk("t6_ch4", {29'd0, c1}, 4);
    bus.request[4] = 1'b0;
    monitor(20, rs, on, bz, c1, c2);
    chk("t6_quiet", rs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
